// File: rtl/serial_receiver_if.sv
// Bundles the nibble-stream inputs and word-level results of the serial
// receiver. The transmitter side drives DIn/DInValid/ClkTx; the receiver
// side drives the received word and its status.
interface serial_receiver_if;
  logic [3:0]  DIn;
  logic        DInValid;
  logic        ClkTx;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        RxBusy;
  logic        RxError;
  logic [7:0]  FrameCount;

  modport master (
    output DIn, DInValid, ClkTx,
    input  DataOut, DataValid, RxBusy, RxError, FrameCount
  );

  modport slave (
    input  DIn, DInValid, ClkTx,
    output DataOut, DataValid, RxBusy, RxError, FrameCount
  );
endinterface

// File: rtl/serial_receiver.sv
// Serial receiver: assembles eight 4-bit nibbles, MS nibble first, into a
// 32-bit word. A nibble is taken on each rising edge of the Clk-synchronous
// ClkTx strobe while DInValid is high. Dropping DInValid mid-frame aborts
// the frame with a one-cycle RxError pulse. All outputs are registered.
module serial_receiver (
  input  logic Clk,
  input  logic Reset,
  serial_receiver_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t      state_r;
  logic [2:0]  cnt_r;        // nibbles held in shift_r (0..7)
  logic [27:0] shift_r;      // first seven nibbles of the frame
  logic        clktx_q_r;
  logic [31:0] dataout_r;
  logic        datavalid_r;
  logic        rxbusy_r;
  logic        rxerror_r;
  logic [7:0]  framecount_r;

  logic        strobe_s;
  logic        capture_s;

  // A capture needs a 0->1 transition of ClkTx while the frame is valid.
  assign strobe_s  = bus.ClkTx & ~clktx_q_r;
  assign capture_s = strobe_s & bus.DInValid;

  // Delay ClkTx by one Clk so a held-high strobe yields a single capture.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clktx_q_r <= 1'b0;
    end else begin
      clktx_q_r <= bus.ClkTx;
    end
  end

  // Frame FSM: nibble assembly, word completion and abort handling.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      shift_r      <= 28'h000_0000;
      dataout_r    <= 32'h0000_0000;
      datavalid_r  <= 1'b0;
      rxbusy_r     <= 1'b0;
      rxerror_r    <= 1'b0;
      framecount_r <= 8'h00;
    end else begin
      datavalid_r <= 1'b0;
      rxerror_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            shift_r  <= {24'h00_0000, bus.DIn};
            cnt_r    <= 3'd1;
            state_r  <= RECV;
            rxbusy_r <= 1'b1;
          end
        end
        RECV: begin
          if (!bus.DInValid) begin
            // Transmitter gave up: throw away the partial word.
            shift_r   <= 28'h000_0000;
            cnt_r     <= 3'd0;
            state_r   <= IDLE;
            rxbusy_r  <= 1'b0;
            rxerror_r <= 1'b1;
          end else if (capture_s) begin
            if (cnt_r == 3'd7) begin
              dataout_r    <= {shift_r, bus.DIn};
              datavalid_r  <= 1'b1;
              framecount_r <= framecount_r + 8'd1;
              shift_r      <= 28'h000_0000;
              cnt_r        <= 3'd0;
              state_r      <= IDLE;
              rxbusy_r     <= 1'b0;
            end else begin
              shift_r <= {shift_r[23:0], bus.DIn};
              cnt_r   <= cnt_r + 3'd1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 3'd0;
          rxbusy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DataOut    = dataout_r;
  assign bus.DataValid  = datavalid_r;
  assign bus.RxBusy     = rxbusy_r;
  assign bus.RxError    = rxerror_r;
  assign bus.FrameCount = framecount_r;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: the stimulus pushes the expected
// word/frame-count for every complete frame it sends; a monitor pops and
// compares on every DataValid pulse.
module tb_serial_receiver;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  fc;
  } exp_t;

  logic clk;
  logic rst;
  serial_receiver_if bus ();

  serial_receiver dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  logic [7:0]  fc_model = 8'h00;
  logic [31:0] last_w = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on DataValid, plus exclusivity of the pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.DataValid && bus.RxError) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dv_err_overlap: both high at %0t", $time);
      end
      if (bus.RxError) err_seen++;
      if (bus.DataValid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: DataValid with DataOut %h, none expected at %0t",
                   bus.DataOut, $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_word", bus.DataOut, e.w);
          chk("sb_count", {24'h0, bus.FrameCount}, {24'h0, e.fc});
        end
      end
    end
  end

  // One nibble: ClkTx high for 'width' cycles, then low for one cycle.
  task automatic send_nib(input logic [3:0] n, input int width);
    @(negedge clk);
    bus.DIn   = n;
    bus.ClkTx = 1'b1;
    repeat (width - 1) @(negedge clk);
    @(negedge clk);
    bus.ClkTx = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int width);
    exp_t e;
    fc_model = fc_model + 8'd1;
    e.w  = w;
    e.fc = fc_model;
    sbq.push_back(e);
    last_w = w;
    bus.DInValid = 1'b1;
    for (int i = 7; i >= 0; i--) send_nib(w[i*4 +: 4], width);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.DInValid = 1'b0;
    bus.ClkTx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fc_model = 8'h00;
  endtask

  initial begin
    int guard;
    logic [31:0] w;
    rst          = 1'b0;
    bus.DIn      = 4'h0;
    bus.DInValid = 1'b0;
    bus.ClkTx    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dataout", bus.DataOut, 32'h0);
    chk("rst_count", {24'h0, bus.FrameCount}, 32'h0);
    chk("rst_flags", {29'h0, bus.DataValid, bus.RxBusy, bus.RxError}, 32'h0);
    rst = 1'b1;

    // Single frame, DataValid exactly 1 Clk after the 8th capture.
    send_word(32'h1234_5678, 1);
    chk("dv_latency", {31'h0, bus.DataValid}, 32'h1);
    @(negedge clk);
    chk("dv_single", {31'h0, bus.DataValid}, 32'h0);
    chk("single_word", bus.DataOut, 32'h1234_5678);
    chk("single_count", {24'h0, bus.FrameCount}, 32'h1);
    bus.DInValid = 1'b0;
    @(negedge clk);
    chk("idle_no_err", {30'h0, bus.RxBusy, bus.RxError}, 32'h0);

    // Back-to-back frames with DInValid held.
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h0000_0001, 1);
    @(negedge clk);
    bus.DInValid = 1'b0;
    chk("b2b_word", bus.DataOut, 32'h0000_0001);
    chk("b2b_count", {24'h0, bus.FrameCount}, 32'h3);

    // Abort after 3 nibbles.
    bus.DInValid = 1'b1;
    send_nib(4'h9, 1);
    send_nib(4'h8, 1);
    send_nib(4'h7, 1);
    chk("busy_mid", {31'h0, bus.RxBusy}, 32'h1);
    @(negedge clk);
    bus.DInValid = 1'b0;
    @(negedge clk);
    chk("abort_err", {31'h0, bus.RxError}, 32'h1);
    chk("abort_busy", {31'h0, bus.RxBusy}, 32'h0);
    @(negedge clk);
    chk("abort_err_pulse", {31'h0, bus.RxError}, 32'h0);
    chk("abort_word_hold", bus.DataOut, 32'h0000_0001);
    chk("abort_count_hold", {24'h0, bus.FrameCount}, 32'h3);
    send_word(32'hCAFE_F00D, 1);
    @(negedge clk);
    bus.DInValid = 1'b0;
    chk("after_abort_word", bus.DataOut, 32'hCAFE_F00D);

    // Wide strobe: ClkTx held 4 cycles per nibble.
    send_word(32'hA5A5_A5A5, 4);
    @(negedge clk);
    bus.DInValid = 1'b0;
    chk("wide_word", bus.DataOut, 32'hA5A5_A5A5);
    chk("wide_count", {24'h0, bus.FrameCount}, 32'h5);

    // Reset after 5 nibbles; ClkTx already high at release counts as nibble 1.
    bus.DInValid = 1'b1;
    for (int i = 0; i < 5; i++) send_nib(4'h3, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.DIn = 4'h0;
    bus.ClkTx = 1'b1;
    #1;
    chk("mid_rst_word", bus.DataOut, 32'h0);
    chk("mid_rst_flags", {21'h0, bus.FrameCount, bus.DataValid, bus.RxBusy, bus.RxError}, 32'h0);
    repeat (2) @(negedge clk);
    fc_model = 8'h00;
    sbq.push_back('{w: 32'h0F0F_0F0F, fc: 8'h01});
    fc_model = 8'h01;
    rst = 1'b1;
    @(negedge clk);
    bus.ClkTx = 1'b0;
    chk("rel_edge_busy", {31'h0, bus.RxBusy}, 32'h1);
    for (int i = 6; i >= 0; i--) send_nib((i % 2 == 0) ? 4'hF : 4'h0, 1);
    @(negedge clk);
    bus.DInValid = 1'b0;
    chk("post_rst_word", bus.DataOut, 32'h0F0F_0F0F);
    chk("post_rst_count", {24'h0, bus.FrameCount}, 32'h1);
    chk("no_err_on_reset", err_seen, 1);

    // 256 frames from reset: count wraps to zero.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      w = 32'h1357_9BDF ^ (i * 32'h0101_0101);
      send_word(w, 1);
    end
    @(negedge clk);
    bus.DInValid = 1'b0;
    chk("wrap_count", {24'h0, bus.FrameCount}, 32'h0);
    chk("wrap_word", bus.DataOut, last_w);

    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named Clk and Reset, with Reset = 0 meaning reset.
REQ-002 Port list (name, direction, width, meaning):
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous active-low reset
- DIn  input  4  nibble from the serial transmitter's DataOut
- DInValid  input  1  transmitter's DOutValid; high for the whole frame
- ClkTx  input  1  transmitter's ClkTx strobe; Clk-synchronous, produced by the frequency divider
- DataOut  output  32  last completely received word
- DataValid  output  1  one-Clk pulse when DataOut is updated
- RxBusy  output  1  high while a frame is partially received
- RxError  output  1  one-Clk pulse when a frame is aborted
- FrameCount  output  8  count of good frames received
REQ-003 The module SHALL have no parameters; the word width is fixed at 32 bits, i.e. 8 nibbles.

Function
REQ-004 ClkTx SHALL be registered each Clk cycle into ClkTx_q; the rising-edge strobe is ClkTx = 1 and ClkTx_q = 0.
REQ-005 A nibble SHALL be captured on a Clk rising edge only when the rising-edge strobe and DInValid = 1 are both present in that cycle.
REQ-006 Frames SHALL be sent most-significant nibble first; the first nibble captured becomes DataOut[31:28] and the eighth becomes DataOut[3:0].
REQ-007 The FSM SHALL have two states:
- IDLE: any capture loads the shift register and sets the nibble count to 1, then moves to RECV.
- RECV: each capture shifts left by 4, inserts DIn and increments the count.
REQ-008 On the Clk edge that captures the 8th nibble, the block SHALL:
- load DataOut with the complete word;
- set DataValid to 1 for exactly the following cycle;
- increment FrameCount;
- clear the count and return to IDLE.
Capture-to-DataValid latency is therefore 1 Clk.
REQ-009 If a new capture happens in the same cycle that DataValid is high, it SHALL start the next frame normally; back-to-back frames SHALL lose no nibble.
REQ-010 In RECV, DInValid = 0 on any Clk edge SHALL:
- abort the frame and discard the partial data;
- pulse RxError for 1 cycle;
- return to IDLE with count 0.
DataOut and FrameCount SHALL be left unchanged.
REQ-011 In IDLE, DInValid = 0 SHALL cause no error and no state change.
REQ-012 RxBusy SHALL be 1 exactly when the FSM is in RECV; it is registered, not combinational.
REQ-013 Arithmetic rules:
- FrameCount is modulo 256 and SHALL wrap from 255 to 0 without any flag.
- The nibble count is 3 bits and SHALL never exceed 8.
REQ-014 A ClkTx level held high for several cycles SHALL produce only one capture; captures occur on rising edges only.
REQ-015 DataValid and RxError SHALL never be high in the same cycle.
REQ-016 DataOut SHALL hold its value between frames until the next good frame completes.

Reset
REQ-017 While Reset = 0, the block SHALL asynchronously force:
- FSM to IDLE, nibble count to 0, shift register to 0, ClkTx_q to 0;
- DataOut = 32'h0000_0000;
- DataValid = 0, RxBusy = 0, RxError = 0, FrameCount = 8'h00.
REQ-018 Reset asserted in the middle of a frame SHALL discard the partial frame with no RxError pulse.
REQ-019 After Reset returns to 1, the first capture SHALL be treated as nibble 1 of a new frame.
REQ-020 A ClkTx that is already high when reset is released SHALL count as a rising edge on the first cycle after release, since ClkTx_q = 0.

Verification
REQ-021 Single good frame: DInValid = 1, nibbles 1,2,...,8 on 8 ClkTx rising edges -> DataOut = 32'h1234_5678, one DataValid pulse 1 Clk after the 8th capture, FrameCount = 1.
REQ-022 Back-to-back frames: send word 32'hDEAD_BEEF, then 32'h0000_0001 with no gap -> two DataValid pulses, DataOut ends at 32'h0000_0001, FrameCount = 2.
REQ-023 Abort: drop DInValid after 3 nibbles -> one RxError pulse, RxBusy returns to 0, DataOut and FrameCount unchanged; the next full frame is received correctly.
REQ-024 Wide strobe: hold ClkTx high for 4 Clk cycles per nibble while sending 32'hA5A5_A5A5 -> exactly 8 captures and DataOut = 32'hA5A5_A5A5.
REQ-025 Reset mid-frame: pull Reset low after 5 nibbles -> all outputs return to their reset values immediately with no RxError; a following frame 32'h0F0F_0F0F is received with FrameCount = 1.
REQ-026 Wrap-around: send 256 good frames -> FrameCount returns to 8'h00 and the final DataOut equals the 256th word.
